// File: rtl/memlog_reader.sv
// rtl/memlog_reader.sv - MEMLog capture buffer read-side dump sequencer
//
// Purpose:
//   Once MEMLog reports a full capture buffer, a start pulse strobes the log
//   into read mode, then walks every BRAM address 0..2^BRAM_ADDR_WIDTH-1 in
//   ascending order and streams each 32-bit word out on a valid/ready port.
//   Dropping i_mem_full while busy aborts the dump.
//
// Optional feature:
//   MEMLOG_RD_CHECKSUM_EN - when defined, one extra word (XOR of every data
//   word sent) follows the last data word before o_done.
//
// Ports:
//   clk                  in   system clock, rising edge
//   i_rst                in   synchronous reset, active-low
//   i_start              in   one-cycle dump request (needs i_mem_full=1)
//   i_mem_full           in   MEMLog full flag; falling while busy aborts
//   o_read_log           out  one-cycle read-mode strobe to MEMLog
//   o_addr_log_to_mem    out  BRAM read address
//   i_data_log_from_mem  in   BRAM read data, READ_LATENCY cycles after address
//   o_data               out  stream data
//   o_valid              out  stream valid
//   i_ready              in   stream ready
//   o_busy               out  dump in progress
//   o_done               out  one-cycle pulse after the final transfer
//   o_abort              out  one-cycle pulse when a dump is aborted

module memlog_reader #(
    parameter int BRAM_ADDR_WIDTH = 15,
    parameter int READ_LATENCY    = 1
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic                       i_mem_full,
    output logic                       o_read_log,
    output logic [BRAM_ADDR_WIDTH-1:0] o_addr_log_to_mem,
    input  logic [31:0]                i_data_log_from_mem,
    output logic [31:0]                o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_abort
);

    localparam int W = BRAM_ADDR_WIDTH;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ARM  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
`ifdef MEMLOG_RD_CHECKSUM_EN
    localparam logic [2:0] S_CSUM = 3'd6;
`endif

    // Address counter carries one spare bit; the last address is held rather
    // than incremented, so the counter can never wrap back to 0 mid-dump.
    localparam logic [W:0] LAST_ADDR = {1'b0, {W{1'b1}}};
    localparam logic [1:0] LAT_LAST  = 2'(READ_LATENCY - 1);

    logic [2:0]  state_q, state_d;
    logic [W:0]  cnt_q, cnt_d;
    logic [1:0]  lat_q, lat_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        abort_q, abort_d;
`ifdef MEMLOG_RD_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    logic xfer;
    assign xfer = valid_q && i_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        data_d  = data_q;
        valid_d = valid_q;
        abort_d = 1'b0;
`ifdef MEMLOG_RD_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_start && i_mem_full) begin
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                cnt_d   = '0;
`ifdef MEMLOG_RD_CHECKSUM_EN
                csum_d  = '0;
`endif
                state_d = S_ADDR;
            end
            S_ADDR: begin
                // Address is already on the bus this cycle; start the latency count.
                lat_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    data_d  = i_data_log_from_mem;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_SEND: begin
                if (xfer) begin
                    valid_d = 1'b0;
`ifdef MEMLOG_RD_CHECKSUM_EN
                    csum_d  = csum_q ^ data_q;
`endif
                    if (cnt_q == LAST_ADDR) begin
`ifdef MEMLOG_RD_CHECKSUM_EN
                        // The running checksum does not yet include this word.
                        data_d  = csum_q ^ data_q;
                        valid_d = 1'b1;
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = S_ADDR;
                    end
                end
            end
`ifdef MEMLOG_RD_CHECKSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase

        // Logger re-armed under us: drop whatever is in flight. DONE is
        // excluded because every word has already been accepted by then.
        if (state_q != S_IDLE && state_q != S_DONE && !i_mem_full) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            abort_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            lat_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
`ifdef MEMLOG_RD_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
`ifdef MEMLOG_RD_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign o_addr_log_to_mem = cnt_q[W-1:0];
    assign o_data            = data_q;
    assign o_valid           = valid_q;
    assign o_abort           = abort_q;
    assign o_busy            = (state_q != S_IDLE);
    assign o_read_log        = (state_q == S_ARM);
    assign o_done            = (state_q == S_DONE);

endmodule

// File: tb/tb_memlog_reader.sv
// tb/tb_memlog_reader.sv - self-checking bench for memlog_reader

module tb_memlog_reader;

    localparam int W  = 4;
    localparam int RL = 1;
    localparam int N  = 1 << W;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic          i_mem_full;
    logic          o_read_log;
    logic [W-1:0]  o_addr_log_to_mem;
    logic [31:0]   i_data_log_from_mem;
    logic [31:0]   o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;
    logic          o_done;
    logic          o_abort;

    always #5 clk = ~clk;

    memlog_reader #(
        .BRAM_ADDR_WIDTH(W),
        .READ_LATENCY   (RL)
    ) dut (
        .clk                (clk),
        .i_rst              (i_rst),
        .i_start            (i_start),
        .i_mem_full         (i_mem_full),
        .o_read_log         (o_read_log),
        .o_addr_log_to_mem  (o_addr_log_to_mem),
        .i_data_log_from_mem(i_data_log_from_mem),
        .o_data             (o_data),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_busy             (o_busy),
        .o_done             (o_done),
        .o_abort            (o_abort)
    );

    // BRAM with a one-cycle registered read
    logic [31:0] mem [N];
    always @(posedge clk) i_data_log_from_mem <= mem[o_addr_log_to_mem];

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] got  [$];
    logic [31:0] expq [$];
    int          rl_cnt, done_cnt, ab_cnt, stab_err;
    bit          prev_hold;
    logic [31:0] prev_data;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Consumer-side view of the current cycle (outputs settled, inputs driven)
    task automatic observe();
        if (o_read_log) rl_cnt++;
        if (o_done)     done_cnt++;
        if (o_abort)    ab_cnt++;
        if (prev_hold && !o_abort && i_rst && (!o_valid || o_data !== prev_data)) stab_err++;
        prev_hold = o_valid && !i_ready;
        prev_data = o_data;
        if (o_valid && i_ready) got.push_back(o_data);
    endtask

    task automatic step(input bit rdy, input bit st);
        i_ready = rdy;
        i_start = st;
        observe();
        @(posedge clk);
        #1;
        i_start = 1'b0;
        if (!i_rst) prev_hold = 1'b0;
    endtask

    task automatic clear_mon();
        got.delete();
        rl_cnt = 0; done_cnt = 0; ab_cnt = 0; stab_err = 0;
        prev_hold = 1'b0;
    endtask

    // Reference: every word in ascending address order, plus XOR of them all
    // when the checksum word is enabled.
    task automatic build_exp();
        logic [31:0] x;
        x = '0;
        expq.delete();
        for (int k = 0; k < N; k++) begin
            expq.push_back(mem[k]);
            x ^= mem[k];
        end
`ifdef MEMLOG_RD_CHECKSUM_EN
        expq.push_back(x);
`endif
    endtask

    task automatic cmp_words(input string tag);
        chk({tag, "_count"}, got.size(), expq.size());
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), got[i], expq[i]);
    endtask

    task automatic run_dump(input int rdy_pct, input int restart_at, output int cyc);
        bit st;
        bit restarted;
        restarted = 1'b0;
        clear_mon();
        build_exp();
        step(1'b1, 1'b1);
        cyc = 0;
        while (done_cnt == 0 && ab_cnt == 0 && cyc < BUDGET) begin
            st = 1'b0;
            if (!restarted && restart_at >= 0 && got.size() == restart_at) begin
                st = 1'b1;
                restarted = 1'b1;
            end
            step(($urandom_range(99) < rdy_pct), st);
            cyc++;
        end
        chk("dump_in_budget", (cyc < BUDGET), 1);
    endtask

    int cyc;
    int bad;

    initial begin
        i_rst = 1'b0; i_start = 1'b0; i_mem_full = 1'b1; i_ready = 1'b0;
        for (int k = 0; k < N; k++) mem[k] = 32'h1000_0000 + k;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b1;

        // Reset state
        chk("rst_busy",  o_busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_rdlog", o_read_log, 0);
        chk("rst_done",  o_done, 0);
        chk("rst_abort", o_abort, 0);
        chk("rst_addr",  o_addr_log_to_mem, 0);
        chk("rst_data",  o_data, 0);

        // 1: ascending pattern, ready held high, minimum cycles per word
        run_dump(100, -1, cyc);
        cmp_words("t1");
        chk("t1_rdlog", rl_cnt, 1);
        chk("t1_done",  done_cnt, 1);
        chk("t1_abort", ab_cnt, 0);
        chk("t1_busy",  o_busy, 0);
`ifdef MEMLOG_RD_CHECKSUM_EN
        chk("t1_cycles", cyc, 1 + (RL + 2) * N + 1 + 1);
`else
        chk("t1_cycles", cyc, 1 + (RL + 2) * N + 1);
`endif

        // 2: start without a full buffer is ignored
        i_mem_full = 1'b0;
        clear_mon();
        bad = 0;
        step(1'b1, 1'b1);
        for (int i = 0; i < 50; i++) begin
            if (o_busy || o_read_log || o_valid) bad++;
            step(1'b1, 1'b0);
        end
        chk("t2_quiet", bad, 0);
        i_mem_full = 1'b1;

        // 3: random data, 50% ready, extra start mid-dump must be ignored
        for (int rep = 0; rep < 3; rep++) begin
            for (int k = 0; k < N; k++) mem[k] = $urandom;
            run_dump(50, 3, cyc);
            cmp_words($sformatf("t3r%0d", rep));
            chk("t3_stable", stab_err, 0);
            chk("t3_rdlog",  rl_cnt, 1);
            chk("t3_done",   done_cnt, 1);
        end

        // 4: abort after the 5th transfer, then restart from address 0
        for (int k = 0; k < N; k++) mem[k] = $urandom;
        clear_mon();
        build_exp();
        step(1'b1, 1'b1);
        cyc = 0;
        while (got.size() < 5 && cyc < BUDGET) begin
            step(($urandom_range(1) == 1), 1'b0);
            cyc++;
        end
        chk("t4_reach5", (cyc < BUDGET), 1);
        i_mem_full = 1'b0;
        step(1'b0, 1'b0);
        chk("t4_abort_pulse", o_abort, 1);
        chk("t4_valid_low",   o_valid, 0);
        chk("t4_idle",        o_busy, 0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        chk("t4_abort_cnt", ab_cnt, 1);
        chk("t4_no_done",   done_cnt, 0);
        chk("t4_partial",   got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("t4_p%0d", i), got[i], expq[i]);
        i_mem_full = 1'b1;
        run_dump(70, -1, cyc);
        cmp_words("t4_restart");
        chk("t4_restart_done", done_cnt, 1);

        // 5: reset during the latency wait of word 7
        clear_mon();
        step(1'b1, 1'b1);
        cyc = 0;
        while (got.size() < 7 && cyc < BUDGET) begin
            step(1'b1, 1'b0);
            cyc++;
        end
        chk("t5_addr7", o_addr_log_to_mem, 7);
        step(1'b1, 1'b0);
        chk("t5_wait_valid", o_valid, 0);
        i_rst = 1'b0;
        step(1'b1, 1'b0);
        i_rst = 1'b1;
        chk("t5_busy",  o_busy, 0);
        chk("t5_valid", o_valid, 0);
        chk("t5_rdlog", o_read_log, 0);
        chk("t5_done",  o_done, 0);
        chk("t5_abort", o_abort, 0);
        chk("t5_addr",  o_addr_log_to_mem, 0);
        chk("t5_data",  o_data, 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        chk("t5_no_done",  done_cnt, 0);
        chk("t5_no_abort", ab_cnt, 0);

        // 6: checksum patterns
        for (int k = 0; k < N; k++) mem[k] = k;
        run_dump(100, -1, cyc);
        cmp_words("t6a");
`ifdef MEMLOG_RD_CHECKSUM_EN
        if (got.size() > 0) chk("t6a_csum", got[got.size()-1], 32'h0000_0000);
`endif
        for (int k = 0; k < N; k++) mem[k] = 32'h1 << k;
        run_dump(60, -1, cyc);
        cmp_words("t6b");
`ifdef MEMLOG_RD_CHECKSUM_EN
        if (got.size() > 0) chk("t6b_csum", got[got.size()-1], 32'h0000_FFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
